t09_snake_body_ctrl: RTL and testbench

Sequencer that owns the snake body coordinate array and advances it once per game tick. On each tick it computes the next head, checks for wall and self-collision by scanning the body one segment per cycle, then shifts the array and optionally grows. Its `body` and `curr_length` outputs feed `t09_location_check` directly; its `game_over` output feeds the game-state logic.

---
 rtl/t09_snake_pkg.sv | 40 ++++
 rtl/t09_next_head.sv | 31 +++
 rtl/t09_snake_body_ctrl.sv | 144 ++++++++++++++
 tb/tb_t09_snake_body_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t09_snake_pkg.sv
// Shared types and constants for the snake body sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package t09_snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [3:0] GRID_MAX = 4'd15;

  localparam logic [7:0] RST_HEAD = 8'h44;
  localparam logic [7:0] RST_SEG1 = 8'h34;
  localparam logic [7:0] RST_SEG2 = 8'h24;

  // UP/DOWN and LEFT/RIGHT differ only in bit 0, so flipping it gives the reverse heading.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  // Starting body: three segments in a row pointing right, the rest cleared.
  function automatic logic [7:0] init_seg(input int idx);
    case (idx)
      0:       return RST_HEAD;
      1:       return RST_SEG1;
      2:       return RST_SEG2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/t09_next_head.sv
// Computes the cell the head moves into and whether that move leaves the grid.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
module t09_next_head
  import t09_snake_pkg::*;
(
  input  logic [7:0] head,
  input  logic [1:0] heading,
  output logic [7:0] next_head,
  output logic       wall_hit
);

  logic [3:0] x;
  logic [3:0] y;

  assign x = head[7:4];
  assign y = head[3:0];

  // Step one cell along heading; on a wall the coordinate is held rather than wrapped.
  always_comb begin
    next_head = head;
    wall_hit  = 1'b0;
    case (heading)
      DIR_UP:    if (y == 4'd0)     wall_hit = 1'b1; else next_head = {x, y - 4'd1};
      DIR_DOWN:  if (y == GRID_MAX) wall_hit = 1'b1; else next_head = {x, y + 4'd1};
      DIR_LEFT:  if (x == 4'd0)     wall_hit = 1'b1; else next_head = {x - 4'd1, y};
      default:   if (x == GRID_MAX) wall_hit = 1'b1; else next_head = {x + 4'd1, y};
    endcase
  end

endmodule

// File: rtl/t09_snake_body_ctrl.sv
// Owns the snake body array and advances it one cell per accepted tick, with wall/self collision.
// Latency: tick to done is N+3 cycles (N = segments scanned), or 2 cycles on a wall abort.
// Backpressure: ticks arriving while busy or after game over are dropped, never queued.
module t09_snake_body_ctrl
  import t09_snake_pkg::*;
#(
  parameter int MAX_LENGTH  = 50,
  parameter int INIT_LENGTH = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    tick,
  input  logic [1:0]              direction,
  input  logic                    grow,
  input  logic                    restart,
  output logic [MAX_LENGTH*8-1:0] body,
  output logic [7:0]              curr_length,
  output logic                    busy,
  output logic                    done,
  output logic                    game_over
);

  localparam int         IDX_W    = $clog2(MAX_LENGTH);
  localparam logic [7:0] LEN_INIT = 8'(INIT_LENGTH);
  localparam logic [7:0] LEN_TOP  = 8'(MAX_LENGTH - 1);

  state_t           state;
  logic [7:0]       body_q [MAX_LENGTH];
  logic [1:0]       heading;
  logic [7:0]       len_q;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] scan_lim;
  logic             grow_pending;
  logic             grow_now;
  logic             busy_q;
  logic             done_q;
  logic             go_q;

  logic [7:0]       next_head;
  logic             wall_hit;
  logic [7:0]       scan_n;

  // Head and heading are both frozen for the whole move, so this stays valid through SHIFT.
  t09_next_head u_next_head (
    .head      (body_q[0]),
    .heading   (heading),
    .next_head (next_head),
    .wall_hit  (wall_hit)
  );

  // Without a grow the tail cell is vacated during the move, so it is not a collision.
  assign scan_n = grow_pending ? len_q : len_q - 8'd1;

  // Move sequencer: latch heading, wall check, serial body scan, single-cycle shift.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < MAX_LENGTH; i++) body_q[i] <= init_seg(i);
      state        <= ST_IDLE;
      heading      <= DIR_RIGHT;
      len_q        <= LEN_INIT;
      scan_idx     <= '0;
      scan_lim     <= '0;
      grow_pending <= 1'b0;
      grow_now     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      go_q         <= 1'b0;
    end else if (restart) begin
      for (int i = 0; i < MAX_LENGTH; i++) body_q[i] <= init_seg(i);
      state        <= ST_IDLE;
      heading      <= DIR_RIGHT;
      len_q        <= LEN_INIT;
      scan_idx     <= '0;
      scan_lim     <= '0;
      grow_pending <= 1'b0;
      grow_now     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      go_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (grow) grow_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick && !go_q) begin
            if (direction != opposite_dir(heading)) heading <= direction;
            state  <= ST_CALC;
            busy_q <= 1'b1;
          end
        end
        ST_CALC: begin
          if (wall_hit) begin
            go_q   <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            grow_now     <= grow_pending;
            grow_pending <= grow;
            scan_lim     <= IDX_W'(scan_n);
            scan_idx     <= IDX_W'(1);
            state        <= (scan_n == 8'd0) ? ST_SHIFT : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (body_q[scan_idx] == next_head) begin
            go_q   <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else if (scan_idx == scan_lim) begin
            state <= ST_SHIFT;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        ST_SHIFT: begin
          for (int i = 1; i < MAX_LENGTH; i++) body_q[i] <= body_q[i-1];
          body_q[0] <= next_head;
          if (grow_now && (len_q < LEN_TOP)) len_q <= len_q + 8'd1;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Flatten the array onto the packed body bus, segment i at [i*8 +: 8].
  for (genvar g = 0; g < MAX_LENGTH; g++) begin : g_body
    assign body[g*8 +: 8] = body_q[g];
  end

  assign curr_length = len_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign game_over   = go_q;

endmodule

// File: tb/tb_t09_snake_body_ctrl.sv
// Bench for the snake body sequencer: directed scenarios plus a random walk against a list model.
// Latency: checks done timing per move against the model's expected cycle count.
// Backpressure: drives ticks while busy/game over and expects them to be dropped.
module tb_t09_snake_body_ctrl;

  localparam int ML = 50;

  logic            clk = 1'b0;
  logic            nrst;
  logic            tick;
  logic [1:0]      direction;
  logic            grow;
  logic            restart;
  logic [ML*8-1:0] body;
  logic [7:0]      curr_length;
  logic            busy;
  logic            done;
  logic            game_over;

  int checks   = 0;
  int failures = 0;

  // Reference model: snake as coordinate lists plus scalar state.
  int mx [ML];
  int my [ML];
  int m_len;
  int m_dir;
  int m_go;
  int m_gp;

  t09_snake_body_ctrl #(.MAX_LENGTH(ML), .INIT_LENGTH(2)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .tick        (tick),
    .direction   (direction),
    .grow        (grow),
    .restart     (restart),
    .body        (body),
    .curr_length (curr_length),
    .busy        (busy),
    .done        (done),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  function automatic int dxof(input int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction

  function automatic int dyof(input int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction

  function automatic logic [ML*8-1:0] model_body();
    logic [ML*8-1:0] r;
    for (int i = 0; i < ML; i++) r[i*8 +: 8] = 8'(mx[i] * 16 + my[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ML; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    mx[0] = 4; my[0] = 4;
    mx[1] = 3; my[1] = 4;
    mx[2] = 2; my[2] = 4;
    m_len = 2;
    m_dir = 3;
    m_go  = 0;
    m_gp  = 0;
  endtask

  // grow_cyc: -1 none, 0 with the tick (applies to this move), >=1 during the move (next move).
  task automatic model_move(input int dir, input int grow_cyc, output int exp_cyc);
    int gp_eff, nx, ny, n, hit;
    gp_eff = (m_gp != 0 || grow_cyc == 0) ? 1 : 0;
    if (!(dxof(dir) + dxof(m_dir) == 0 && dyof(dir) + dyof(m_dir) == 0)) m_dir = dir;
    nx = mx[0] + dxof(m_dir);
    ny = my[0] + dyof(m_dir);
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
      m_go    = 1;
      exp_cyc = 2;
      m_gp    = (gp_eff != 0 || grow_cyc >= 1) ? 1 : 0;
    end else begin
      n   = (gp_eff != 0) ? m_len : m_len - 1;
      hit = 0;
      for (int i = 1; i <= n; i++)
        if (hit == 0 && mx[i] == nx && my[i] == ny) hit = i;
      m_gp = (grow_cyc >= 1) ? 1 : 0;
      if (hit != 0) begin
        m_go    = 1;
        exp_cyc = 2 + hit;
      end else begin
        exp_cyc = n + 3;
        for (int i = ML - 1; i >= 1; i--) begin
          mx[i] = mx[i-1];
          my[i] = my[i-1];
        end
        mx[0] = nx;
        my[0] = ny;
        if (gp_eff != 0 && m_len < ML - 1) m_len = m_len + 1;
      end
    end
  endtask

  task automatic apply_reset();
    nrst      = 1'b0;
    tick      = 1'b0;
    grow      = 1'b0;
    restart   = 1'b0;
    direction = 2'd3;
    #12;
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
  endtask

  // One accepted move: optional grow pulse and extra (ignored) tick at given cycle offsets.
  task automatic run_move(input int dir, input int grow_cyc, input int extra_tick_cyc, input string name);
    int exp_cyc, cnt;
    bit seen;
    model_move(dir, grow_cyc, exp_cyc);
    @(negedge clk);
    direction = 2'(dir);
    tick      = 1'b1;
    grow      = (grow_cyc == 0);
    @(posedge clk);
    #1;
    tick = 1'b0;
    grow = 1'b0;
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < ML + 10) begin
      @(negedge clk);
      cnt++;
      grow = (cnt == grow_cyc);
      tick = (cnt == extra_tick_cyc);
      if (done === 1'b1) seen = 1;
    end
    @(negedge clk);
    grow = 1'b0;
    tick = 1'b0;
    checks++;
    if (!seen || cnt != exp_cyc) begin
      failures++;
      $display("FAIL %s done_cycle seen=%0d got=%0d expected=%0d", name, seen, cnt, exp_cyc);
    end
    checks++;
    if (body !== model_body()) begin
      failures++;
      $display("FAIL %s body got=%h expected=%h", name, body, model_body());
    end
    checks++;
    if (curr_length !== 8'(m_len)) begin
      failures++;
      $display("FAIL %s curr_length got=%0d expected=%0d", name, curr_length, m_len);
    end
    checks++;
    if (game_over !== 1'(m_go)) begin
      failures++;
      $display("FAIL %s game_over got=%b expected=%0d", name, game_over, m_go);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after busy=%b done=%b expected 0/0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (body !== model_body() || body[7:0] !== 8'h44) begin
      failures++;
      $display("FAIL reset_body got=%h expected=%h", body, model_body());
    end
    checks++;
    if (curr_length !== 8'd2 || busy !== 1'b0 || done !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags len=%0d busy=%b done=%b go=%b expected 2/0/0/0",
               curr_length, busy, done, game_over);
    end
  endtask

  task automatic test_straight();
    apply_reset();
    run_move(3, -1, -1, "straight");
    checks++;
    if (body[23:0] !== 24'h344454) begin
      failures++;
      $display("FAIL straight_segs got=%h expected=344454", body[23:0]);
    end
  endtask

  task automatic test_reversal();
    apply_reset();
    run_move(2, -1, -1, "reversal");
    checks++;
    if (body[7:0] !== 8'h54) begin
      failures++;
      $display("FAIL reversal_head got=%h expected=54", body[7:0]);
    end
  endtask

  task automatic test_grow_mid_scan();
    apply_reset();
    run_move(3, 2, -1, "grow_scan_move1");
    checks++;
    if (curr_length !== 8'd2) begin
      failures++;
      $display("FAIL grow_scan_len1 got=%0d expected=2", curr_length);
    end
    run_move(3, -1, -1, "grow_scan_move2");
    checks++;
    if (curr_length !== 8'd3 || body[31:24] !== 8'h34) begin
      failures++;
      $display("FAIL grow_scan_len2 len=%0d tail=%h expected 3/34", curr_length, body[31:24]);
    end
  endtask

  task automatic test_wall();
    logic [ML*8-1:0] snap;
    bit bad;
    apply_reset();
    for (int i = 0; i < 11; i++) run_move(3, -1, -1, "wall_approach");
    snap = body;
    run_move(3, -1, -1, "wall_hit");
    checks++;
    if (game_over !== 1'b1 || body !== snap) begin
      failures++;
      $display("FAIL wall_abort go=%b body_changed=%b expected 1/0", game_over, body !== snap);
    end
    // Tick after game over must be dropped.
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    bad  = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || body !== snap) begin
      failures++;
      $display("FAIL wall_tick_ignored activity=%b body_changed=%b expected 0/0", bad, body !== snap);
    end
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    checks++;
    if (game_over !== 1'b0 || body !== model_body() || curr_length !== 8'd2) begin
      failures++;
      $display("FAIL wall_restart go=%b len=%0d expected 0/2", game_over, curr_length);
    end
  endtask

  task automatic test_self_collision();
    apply_reset();
    run_move(3, 0, -1, "loop_build");
    run_move(1, -1, -1, "loop_down");
    run_move(2, -1, -1, "loop_left");
    run_move(0, -1, -1, "tail_chase");
    checks++;
    if (game_over !== 1'b0) begin
      failures++;
      $display("FAIL tail_chase_go got=%b expected=0", game_over);
    end
    run_move(3, 0, -1, "self_hit");
    checks++;
    if (game_over !== 1'b1) begin
      failures++;
      $display("FAIL self_hit_go got=%b expected=1", game_over);
    end
  endtask

  task automatic test_restart_scan();
    apply_reset();
    run_move(1, -1, -1, "pre_restart");
    @(negedge clk);
    direction = 2'd1;
    tick      = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(negedge clk);           // CALC
    grow = 1'b1;
    @(negedge clk);           // SCAN
    grow    = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    checks++;
    if (body !== model_body() || curr_length !== 8'd2) begin
      failures++;
      $display("FAIL restart_scan_body len=%0d body=%h expected len 2 body=%h",
               curr_length, body, model_body());
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL restart_scan_flags busy=%b done=%b go=%b expected 0/0/0", busy, done, game_over);
    end
    // Pending grow was wiped, so this move must not lengthen the snake.
    run_move(3, -1, -1, "post_restart");
  endtask

  task automatic test_nrst_scan();
    apply_reset();
    run_move(1, -1, -1, "pre_nrst");
    @(negedge clk);
    direction = 2'd2;
    tick      = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (body !== model_body() || curr_length !== 8'd2 || busy !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL nrst_scan len=%0d busy=%b go=%b body=%h expected 2/0/0 body=%h",
               curr_length, busy, game_over, body, model_body());
    end
    @(negedge clk);
    nrst = 1'b1;
    run_move(3, -1, -1, "post_nrst");
  endtask

  task automatic test_busy_tick();
    apply_reset();
    run_move(1, -1, 2, "busy_tick_scan");
    run_move(1, -1, 3, "busy_tick_shift");
    run_move(2, -1, 4, "busy_tick_done");
  endtask

  task automatic test_random();
    int gc;
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      if (m_go != 0) begin
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        model_reset();
        checks++;
        if (game_over !== 1'b0 || body !== model_body()) begin
          failures++;
          $display("FAIL random_restart go=%b body=%h expected 0 body=%h", game_over, body, model_body());
        end
      end else begin
        gc = int'($urandom_range(0, 5));
        if (gc > 2) gc = -1;
        run_move(int'($urandom_range(0, 3)), gc, -1, "random_move");
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_reversal();
    test_grow_mid_scan();
    test_wall();
    test_self_collision();
    test_restart_scan();
    test_nrst_scan();
    test_busy_tick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
